// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory.
// Access sizes, FSM states and the legal response-latency range.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Illegal size or an address not aligned to its natural boundary
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/replication and load
// extraction with sign or zero extension (little-endian).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] sh;

    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        rdata = 32'h0;
        sh    = rword >> {offset, 3'b000};
        unique case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wword = {4{wdata[7:0]}};
                rdata = uns ? {24'h0, sh[7:0]}
                            : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                be    = 4'b0011 << offset;
                wword = {2{wdata[15:0]}};
                rdata = uns ? {16'h0, sh[15:0]}
                            : {{16{sh[15]}}, sh[15:0]};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                rdata = sh;
            end
            default: begin
                be    = 4'b0000;
                rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized loads/stores and fixed latency.
// Optional DATA_MEMORY_PERF_CNT_EN adds saturating load/store counters.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        stall_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] data_o
`ifdef DATA_MEMORY_PERF_CNT_EN
    ,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(LAT_MAX + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                err_q;
    logic [31:0]         load_q;

    logic [7:0]          mem [DEPTH];

    logic                accept;
    logic                oor;
    logic                req_err;
    logic                enter_done;
    logic                commit;
    logic                src_we;
    logic [1:0]          src_size;
    logic                src_uns;
    logic [ADDR_W-1:0]   src_addr;
    logic [31:0]         src_data;
    logic [ADDR_W-1:0]   base;
    logic [31:0]         rword;
    logic [3:0]          be;
    logic [31:0]         wword;
    logic [31:0]         ld_data;

    assign accept  = (state == ST_IDLE) && req_i;
    assign oor     = (ADDR_W < 32) && ((addr_i >> ADDR_W) != 32'h0);
    assign req_err = misaligned(size_i, addr_i[1:0]) || oor;

    // A latency-1 access reaches DONE straight from IDLE, before the
    // request fields are latched, so the datapath reads the live inputs.
    always_comb begin
        if (state == ST_IDLE) begin
            src_we   = we_i;
            src_size = size_i;
            src_uns  = unsigned_i;
            src_addr = addr_i[ADDR_W-1:0];
            src_data = data_i;
        end else begin
            src_we   = we_q;
            src_size = size_q;
            src_uns  = uns_q;
            src_addr = addr_q;
            src_data = data_q;
        end
    end

    assign enter_done = (accept && (req_err || LATENCY == 1))
                     || (state == ST_WAIT && cnt == CNT_W'(1));
    assign commit     = enter_done && !(accept && req_err);

    assign base  = {src_addr[ADDR_W-1:2], 2'b00};
    assign rword = {mem[base | ADDR_W'(3)], mem[base | ADDR_W'(2)],
                    mem[base | ADDR_W'(1)], mem[base]};

    dmem_lane_align u_align (
        .size   (src_size),
        .offset (src_addr[1:0]),
        .uns    (src_uns),
        .wdata  (src_data),
        .rword  (rword),
        .be     (be),
        .wword  (wword),
        .rdata  (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            we_q   <= 1'b0;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
            addr_q <= '0;
            data_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q   <= we_i;
                        size_q <= size_i;
                        uns_q  <= unsigned_i;
                        addr_q <= addr_i[ADDR_W-1:0];
                        data_q <= data_i;
                        err_q  <= req_err;
                        if (req_err || LATENCY == 1) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            load_q <= 32'h0;
        end else if (commit && !src_we) begin
            load_q <= ld_data;
        end
    end

    // Array is never reset; the rst_i gate keeps an aborted store out.
    always_ff @(posedge clk_i) begin
        if (rst_i && commit && src_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[base | ADDR_W'(i)] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign ready_o = (state == ST_IDLE);
    assign stall_o = accept || (state == ST_WAIT);
    assign valid_o = (state == ST_DONE);
    assign err_o   = valid_o && err_q;
    assign data_o  = load_q;

`ifdef DATA_MEMORY_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_o <= 32'h0;
            wr_cnt_o <= 32'h0;
        end else if (state == ST_DONE && !err_q) begin
            if (we_q && wr_cnt_o != 32'hFFFF_FFFF) begin
                wr_cnt_o <= wr_cnt_o + 32'h1;
            end
            if (!we_q && rd_cnt_o != 32'hFFFF_FFFF) begin
                rd_cnt_o <= rd_cnt_o + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: latency-2 instance for the
// main sequence plus a latency-1 instance for back-to-back requests.
module tb_data_memory_sized;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        ready, stall, valid, err;
    logic [31:0] rdata;

    logic        req1 = 1'b0, we1 = 1'b0, uns1 = 1'b0;
    logic [1:0]  size1 = 2'b00;
    logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
    logic        ready1, stall1, valid1, err1;
    logic [31:0] rdata1;

    int n_run = 0;
    int n_fail = 0;
    int cyc;
    logic e;

    always #5 clk = ~clk;

    data_memory_sized #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we),
        .size_i(size), .unsigned_i(uns), .addr_i(addr),
        .data_i(wdata), .ready_o(ready), .stall_o(stall),
        .valid_o(valid), .err_o(err), .data_o(rdata)
    );

    data_memory_sized #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we1),
        .size_i(size1), .unsigned_i(uns1), .addr_i(addr1),
        .data_i(wdata1), .ready_o(ready1), .stall_o(stall1),
        .valid_o(valid1), .err_o(err1), .data_o(rdata1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; returns cycles to valid and err.
    task automatic access(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d,
                          output int c, output logic er);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        step();
        req = 1'b0;
        c = 1;
        while (valid !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        er = err;
        step();
    endtask

    initial begin
        #3;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_data", rdata, 32'h0);
        step();
        step();
        #2 rst_n = 1'b1;
        step();

        req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h10;
        wdata = 32'h1122_3344;
        #1;
        chk("st_T_stall", {31'b0, stall}, 32'd1);
        chk("st_T_ready", {31'b0, ready}, 32'd1);
        step();
        req = 1'b0;
        #1;
        chk("st_T1_stall", {31'b0, stall}, 32'd1);
        chk("st_T1_valid", {31'b0, valid}, 32'd0);
        chk("st_T1_ready", {31'b0, ready}, 32'd0);
        step();
        chk("st_T2_valid", {31'b0, valid}, 32'd1);
        chk("st_T2_err", {31'b0, err}, 32'd0);
        chk("st_T2_stall", {31'b0, stall}, 32'd0);
        chk("st_T2_ready", {31'b0, ready}, 32'd0);
        step();
        chk("st_T3_ready", {31'b0, ready}, 32'd1);
        chk("st_T3_valid", {31'b0, valid}, 32'd0);

        access(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, cyc, e);
        chk("lb13_lat", cyc, 32'd2);
        chk("lb13_err", {31'b0, e}, 32'd0);
        chk("lb13_data", rdata, 32'h0000_0011);

        access(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hABCD_EF80, cyc, e);
        chk("sb12_lat", cyc, 32'd2);
        chk("sb12_err", {31'b0, e}, 32'd0);
        access(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, cyc, e);
        chk("lb12_s", rdata, 32'hFFFF_FF80);
        access(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, cyc, e);
        chk("lbu12", rdata, 32'h0000_0080);
        access(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, cyc, e);
        chk("lh12", rdata, 32'h0000_1180);
        access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, cyc, e);
        chk("lw10", rdata, 32'h1180_3344);

        access(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, cyc, e);
        chk("lw11_lat", cyc, 32'd1);
        chk("lw11_err", {31'b0, e}, 32'd1);
        chk("lw11_keep", rdata, 32'h1180_3344);
        access(1'b1, SZ_HALF, 1'b0, 32'h13, 32'hFFFF_FFFF, cyc, e);
        chk("sh13_err", {31'b0, e}, 32'd1);
        access(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, cyc, e);
        chk("sz11_err", {31'b0, e}, 32'd1);
        chk("sz11_lat", cyc, 32'd1);
        access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, cyc, e);
        chk("lw10_again", rdata, 32'h1180_3344);
        chk("lw10_again_err", {31'b0, e}, 32'd0);

        access(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234_8001, cyc, e);
        access(1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, cyc, e);
        chk("lh16_s", rdata, 32'hFFFF_8001);
        access(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, cyc, e);
        chk("lhu16", rdata, 32'h0000_8001);

        access(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, cyc, e);
        access(1'b1, SZ_WORD, 1'b0, 32'h400, 32'hDEAD_BEEF, cyc, e);
        chk("sw400_err", {31'b0, e}, 32'd1);
        chk("sw400_lat", cyc, 32'd1);
        access(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, cyc, e);
        chk("lw0", rdata, 32'hCAFE_F00D);
        access(1'b1, SZ_BYTE, 1'b0, 32'h3FF, 32'h0000_005A, cyc, e);
        chk("sb3ff_err", {31'b0, e}, 32'd0);
        access(1'b0, SZ_BYTE, 1'b1, 32'h3FF, 32'h0, cyc, e);
        chk("lbu3ff", rdata, 32'h0000_005A);

        req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h10;
        wdata = 32'h5555_5555;
        step();
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_valid", {31'b0, valid}, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_data", rdata, 32'h0);
        step();
        #2 rst_n = 1'b1;
        step();
        access(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, cyc, e);
        chk("abort_lw10", rdata, 32'h1180_3344);

        req1 = 1'b1; we1 = 1'b1; size1 = SZ_WORD; addr1 = 32'h0;
        wdata1 = 32'h1234_5678;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("b2b_valid", {31'b0, valid1}, 32'(k % 2));
            chk("b2b_ready", {31'b0, ready1}, 32'((k + 1) % 2));
            chk("b2b_err", {31'b0, err1}, 32'd0);
        end
        we1 = 1'b0;
        step();
        chk("l1_valid", {31'b0, valid1}, 32'd1);
        chk("l1_data", rdata1, 32'h1234_5678);
        req1 = 1'b0;
        step();
        chk("l1_idle", {31'b0, ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
